// File: rtl/pwm_capture.sv
// Measures PWM duty (high clocks per rising-edge period), flags period errors and stuck inputs.
// Latency: 3 cycles from pwm_i edge to valid_o, or 5 when PWM_CAPTURE_FILTER_EN adds the glitch filter.
// Backpressure: none; valid_o is a one-cycle strobe and the outputs hold until the next strobe.
module pwm_capture #(
  parameter int PERIOD  = 256,
  parameter int TIMEOUT = 512
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       pwm_i,
  output logic [7:0] duty_cycle_o,
  output logic       valid_o,
  output logic       period_err_o,
  output logic       stuck_o
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  typedef enum logic [1:0] {IDLE, MEASURE, STUCK} state_t;

  logic             r_sync1, r_sync2;
  logic             r_lvl_d;
  logic             r_rise, r_fall;
  logic             w_lvl, w_rise, w_fall;
  state_t           r_state, w_state_nxt;
  logic [CNT_W-1:0] r_per, r_hi, w_per_nxt, w_hi_nxt, w_per_inc, w_hi_inc;
  logic [7:0]       r_duty, w_duty_nxt, w_duty_sat;
  logic             r_valid, w_valid_nxt;
  logic             r_err, w_err_nxt;
  logic             r_stuck, w_stuck_nxt;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
    end else begin
      r_sync1 <= pwm_i;
      r_sync2 <= r_sync1;
    end
  end

`ifdef PWM_CAPTURE_FILTER_EN
  // Level follows the synchronized input only once three consecutive samples agree.
  logic [1:0] r_hist;
  logic       r_filt;
  logic       w_filt;

  assign w_filt = (r_sync2 == r_hist[0] && r_sync2 == r_hist[1]) ? r_sync2 : r_filt;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_hist <= 2'b00;
      r_filt <= 1'b0;
    end else begin
      r_hist <= {r_hist[0], r_sync2};
      r_filt <= w_filt;
    end
  end

  assign w_lvl = w_filt;
`else
  assign w_lvl = r_sync2;
`endif

  assign w_rise = w_lvl & ~r_lvl_d;
  assign w_fall = ~w_lvl & r_lvl_d;

  // Edges are registered; r_lvl_d is the level aligned with r_rise/r_fall.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_lvl_d <= 1'b0;
      r_rise  <= 1'b0;
      r_fall  <= 1'b0;
    end else begin
      r_lvl_d <= w_lvl;
      r_rise  <= w_rise;
      r_fall  <= w_fall;
    end
  end

  assign w_per_inc  = (r_per == CNT_MAX) ? r_per : r_per + CNT_ONE;
  assign w_hi_inc   = (!r_lvl_d || r_hi == CNT_MAX) ? r_hi : r_hi + CNT_ONE;
  assign w_duty_sat = (r_hi > CNT_W'(255)) ? 8'hFF : r_hi[7:0];

  always_comb begin
    w_state_nxt = r_state;
    w_per_nxt   = w_per_inc;
    w_hi_nxt    = w_hi_inc;
    w_duty_nxt  = r_duty;
    w_valid_nxt = 1'b0;
    w_err_nxt   = r_err;
    w_stuck_nxt = r_stuck;
    case (r_state)
      IDLE: begin
        w_hi_nxt = '0;
        if (r_rise) begin
          w_per_nxt   = CNT_ONE;
          w_hi_nxt    = CNT_ONE;
          w_state_nxt = MEASURE;
        end else if (r_per == CNT_W'(TIMEOUT)) begin
          w_state_nxt = STUCK;
          w_duty_nxt  = r_lvl_d ? 8'hFF : 8'h00;
          w_stuck_nxt = 1'b1;
          w_err_nxt   = 1'b0;
          w_valid_nxt = 1'b1;
        end
      end
      MEASURE: begin
        if (r_rise) begin
          w_duty_nxt  = w_duty_sat;
          w_err_nxt   = (r_per != CNT_W'(PERIOD));
          w_stuck_nxt = 1'b0;
          w_valid_nxt = 1'b1;
          w_per_nxt   = CNT_ONE;
          w_hi_nxt    = CNT_ONE;
        end else if (r_per == CNT_W'(TIMEOUT)) begin
          w_state_nxt = STUCK;
          w_duty_nxt  = r_lvl_d ? 8'hFF : 8'h00;
          w_stuck_nxt = 1'b1;
          w_err_nxt   = 1'b0;
          w_valid_nxt = 1'b1;
        end
      end
      STUCK: begin
        // stuck_o stays set until a full period has been measured again.
        if (r_rise) begin
          w_per_nxt   = CNT_ONE;
          w_hi_nxt    = CNT_ONE;
          w_state_nxt = MEASURE;
        end else if (r_fall) begin
          w_duty_nxt  = 8'h00;
          w_valid_nxt = 1'b1;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state <= IDLE;
      r_per   <= '0;
      r_hi    <= '0;
      r_duty  <= 8'h00;
      r_valid <= 1'b0;
      r_err   <= 1'b0;
      r_stuck <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_per   <= w_per_nxt;
      r_hi    <= w_hi_nxt;
      r_duty  <= w_duty_nxt;
      r_valid <= w_valid_nxt;
      r_err   <= w_err_nxt;
      r_stuck <= w_stuck_nxt;
    end
  end

  assign duty_cycle_o = r_duty;
  assign valid_o      = r_valid;
  assign period_err_o = r_err;
  assign stuck_o      = r_stuck;

endmodule
